// File: rtl/control_c_writer_pkg.sv
// Shared types for the C write-back path: datatype/addrgen descriptor, writer FSM states,
// and byte-strobe patterns per datatype.
package control_c_writer_pkg;

    typedef enum logic [1:0] {
        DtInt8 = 2'd0,
        DtInt4 = 2'd1,
        DtFp16 = 2'd2,
        DtFp32 = 2'd3
    } datatype_e;

    typedef struct packed {
        datatype_e dtype;
    } addrgen_t;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } ctlc_state_t;

    localparam logic [3:0] Fp16Strb = 4'b0011;
    localparam logic [3:0] FullStrb = 4'b1111;

    function automatic logic [3:0] strb_for(datatype_e dt);
        return (dt == DtFp16) ? Fp16Strb : FullStrb;
    endfunction

endpackage

// File: rtl/control_c_fifo.sv
// Aligned-row FIFO: flop storage with head read straight from the register array.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module control_c_fifo #(
    parameter int unsigned Width = 256,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic             push_en;
    logic             pop_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);
    assign data_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned k = 0; k < Depth; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
                wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/control_c_writer.sv
// C write-back: de-skews PE result lanes, buffers aligned rows and writes them to the C banks.
// Optional macro CONTROL_C_SKEW_CHECK_EN adds the sticky skew_err_o partial-row flag.
module control_c_writer
    import control_c_writer_pkg::*;
#(
    parameter int unsigned Lanes     = 8,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [AddrWidth-1:0]       base_addr_i,
    input  logic [7:0]                 row_cnt_i,
    input  addrgen_t                   addrtype_i,
    input  logic [Lanes-1:0]           res_valid_i,
    input  logic [Lanes*DataWidth-1:0] res_data_i,
    input  logic                       wr_ready_i,
    output logic [Lanes-1:0]           we_o,
    output logic [Lanes*4-1:0]         wstrb_o,
    output logic [AddrWidth-1:0]       wraddr_o,
    output logic [Lanes*DataWidth-1:0] wrdata_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       overflow_o
`ifdef CONTROL_C_SKEW_CHECK_EN
    ,
    output logic                       skew_err_o
`endif
);
    localparam int unsigned RowW = Lanes * DataWidth;

    ctlc_state_t          state_q, state_d;
    logic [AddrWidth-1:0] base_q, base_d;
    logic [7:0]           row_cnt_q, row_cnt_d;
    logic [7:0]           pushed_q, pushed_d;
    logic [7:0]           written_q, written_d;
    datatype_e            dtype_q, dtype_d;
    logic                 overflow_q, overflow_d;
    logic                 zero_done_q, zero_done_d;

    logic [Lanes-1:0] dly_valid;
    logic [RowW-1:0]  dly_data;
    logic [RowW-1:0]  head_data;
    logic             fifo_full, fifo_empty;
    logic             aligned, collecting, start_ok;
    logic             push_req, push_ok, drop, we_any, pop;

    // Lane i lags lane 0 by i cycles, so it is held back Lanes-1-i stages.
    for (genvar i = 0; i < Lanes; i++) begin : g_lane
        localparam int unsigned Dly = Lanes - 1 - i;
        if (Dly == 0) begin : g_pass
            assign dly_valid[i] = res_valid_i[i];
            assign dly_data[i*DataWidth +: DataWidth] = res_data_i[i*DataWidth +: DataWidth];
        end else begin : g_pipe
            logic [Dly-1:0]       v_q;
            logic [DataWidth-1:0] d_q [Dly];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    v_q <= '0;
                    for (int unsigned k = 0; k < Dly; k++) begin
                        d_q[k] <= '0;
                    end
                end else begin
                    v_q[0] <= res_valid_i[i];
                    d_q[0] <= res_data_i[i*DataWidth +: DataWidth];
                    for (int unsigned k = 1; k < Dly; k++) begin
                        v_q[k] <= v_q[k-1];
                        d_q[k] <= d_q[k-1];
                    end
                end
            end
            assign dly_valid[i] = v_q[Dly-1];
            assign dly_data[i*DataWidth +: DataWidth] = d_q[Dly-1];
        end
    end

    assign aligned    = &dly_valid;
    assign collecting = (state_q == StCollect);
    assign start_ok   = start_i && (state_q == StIdle);
    assign we_any     = collecting && !fifo_empty;
    assign pop        = we_any && wr_ready_i;
    assign push_req   = aligned && collecting && (pushed_q < row_cnt_q);
    assign drop       = push_req && fifo_full && !pop;
    assign push_ok    = push_req && !drop;

    control_c_fifo #(
        .Width (RowW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_ok),
        .data_i  (dly_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start_i && (row_cnt_i != 8'd0)) state_d = StCollect;
            StCollect: if (pop && ((written_q + 8'd1) == row_cnt_q)) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        base_d      = base_q;
        row_cnt_d   = row_cnt_q;
        pushed_d    = pushed_q;
        written_d   = written_q;
        dtype_d     = dtype_q;
        overflow_d  = overflow_q;
        zero_done_d = start_ok && (row_cnt_i == 8'd0);
        if (start_ok) begin
            overflow_d = 1'b0;
            if (row_cnt_i != 8'd0) begin
                base_d    = base_addr_i;
                row_cnt_d = row_cnt_i;
                dtype_d   = addrtype_i.dtype;
                pushed_d  = 8'd0;
                written_d = 8'd0;
            end
        end else begin
            if (push_ok) pushed_d = pushed_q + 8'd1;
            if (pop)     written_d = written_q + 8'd1;
            if (drop)    overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q      <= '0;
            row_cnt_q   <= '0;
            pushed_q    <= '0;
            written_q   <= '0;
            dtype_q     <= DtInt8;
            overflow_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            base_q      <= base_d;
            row_cnt_q   <= row_cnt_d;
            pushed_q    <= pushed_d;
            written_q   <= written_d;
            dtype_q     <= dtype_d;
            overflow_q  <= overflow_d;
            zero_done_q <= zero_done_d;
        end
    end

    always_comb begin
        we_o       = {Lanes{we_any}};
        wstrb_o    = {Lanes{strb_for(dtype_q)}};
        wraddr_o   = base_q + AddrWidth'(written_q);
        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StDone) || zero_done_q;
        overflow_o = overflow_q;
        wrdata_o   = head_data;
        if (dtype_q == DtFp16) begin
            for (int unsigned l = 0; l < Lanes; l++) begin
                wrdata_o[l*DataWidth+16 +: DataWidth-16] = '0;
            end
        end
    end

`ifdef CONTROL_C_SKEW_CHECK_EN
    logic skew_err_q, skew_err_d;
    logic partial;

    // A partial row never reaches the push path because aligned stays low.
    assign partial = (|dly_valid) && !aligned;

    always_comb begin
        skew_err_d = skew_err_q;
        if (start_ok) begin
            skew_err_d = 1'b0;
        end else if (partial && collecting) begin
            skew_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skew_err_q <= 1'b0;
        end else begin
            skew_err_q <= skew_err_d;
        end
    end

    assign skew_err_o = skew_err_q;
`endif

endmodule

// File: tb/tb_control_c_writer.sv
// Scoreboard bench for control_c_writer: expected rows are queued as skewed lanes are driven
// and checked against every accepted SRAM write.
module tb_control_c_writer;
    import control_c_writer_pkg::*;

    localparam int unsigned LANES = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ROWW  = LANES * DW;

    logic              clk;
    logic              rst_ni;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [7:0]        row_cnt;
    addrgen_t          addrtype;
    logic [LANES-1:0]  res_valid;
    logic [ROWW-1:0]   res_data;
    logic              wr_ready;
    logic [LANES-1:0]  we;
    logic [LANES*4-1:0] wstrb;
    logic [AW-1:0]     wraddr;
    logic [ROWW-1:0]   wrdata;
    logic              busy;
    logic              done;
    logic              overflow;
`ifdef CONTROL_C_SKEW_CHECK_EN
    logic              skew_err;
`endif

    control_c_writer #(
        .Lanes     (LANES),
        .DataWidth (DW),
        .AddrWidth (AW),
        .FifoDepth (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .base_addr_i (base_addr),
        .row_cnt_i   (row_cnt),
        .addrtype_i  (addrtype),
        .res_valid_i (res_valid),
        .res_data_i  (res_data),
        .wr_ready_i  (wr_ready),
        .we_o        (we),
        .wstrb_o     (wstrb),
        .wraddr_o    (wraddr),
        .wrdata_o    (wrdata),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (overflow)
`ifdef CONTROL_C_SKEW_CHECK_EN
        ,
        .skew_err_o  (skew_err)
`endif
    );

    typedef struct {
        logic [AW-1:0]      addr;
        logic [ROWW-1:0]    data;
        logic [LANES*4-1:0] strb;
    } exp_t;

    exp_t            sb[$];
    logic [DW-1:0]   tab [16][LANES];
    int              n_cmp = 0;
    int              n_err = 0;
    int              cyc = 0;
    int              nwr = 0;
    int              last_wr_cyc = 0;
    logic [ROWW-1:0] last_wrdata;
    logic [LANES*4-1:0] last_wstrb;
    logic [LANES-1:0] all_we;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [ROWW-1:0] got,
                            input logic [ROWW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every accepted write is matched against the oldest expected row.
    always @(negedge clk) begin
        if (rst_ni && (we != '0)) begin
            check_eq("we_all_ones", we, all_we);
            if (wr_ready) begin
                nwr++;
                last_wr_cyc = cyc;
                last_wrdata = wrdata;
                last_wstrb  = wstrb;
                if (sb.size() == 0) begin
                    check_eq("unexpected_write", wraddr, ~wraddr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("wr_addr", wraddr, e.addr);
                    check_eq("wr_data", wrdata, e.data);
                    check_eq("wr_strb", wstrb, e.strb);
                end
            end
        end
    end

    task automatic fill_rows();
        for (int r = 0; r < 16; r++)
            for (int i = 0; i < LANES; i++) tab[r][i] = $urandom;
    endtask

    task automatic expect_rows(input logic [AW-1:0] base, input int r0, input int n,
                               input bit fp16);
        for (int r = r0; r < r0 + n; r++) begin
            exp_t e;
            logic [DW-1:0] w;
            for (int i = 0; i < LANES; i++) begin
                w = tab[r][i];
                if (fp16) w[31:16] = 16'h0;
                e.data[i*DW +: DW] = w;
            end
            e.strb = fp16 ? {LANES{4'b0011}} : {LANES{4'b1111}};
            e.addr = base + AW'(r);
            sb.push_back(e);
        end
    endtask

    // Drives rows r0..r0+n-1 back to back with lane i lagging lane 0 by i cycles.
    task automatic send_rows(input int r0, input int n, input bit early3);
        for (int t = 0; t < n + int'(LANES) - 1; t++) begin
            @(posedge clk); #1;
            for (int i = 0; i < LANES; i++) begin
                int lag;
                int r;
                lag = (early3 && i == 3) ? 2 : i;
                r = t - lag;
                res_valid[i] = (r >= 0 && r < n);
                res_data[i*DW +: DW] = (r >= 0 && r < n) ? tab[r0 + r][i] : '0;
            end
        end
        @(posedge clk); #1;
        res_valid = '0;
        res_data  = '0;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [7:0] cnt,
                             input datatype_e dt);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        row_cnt = cnt;
        addrtype.dtype = dt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        bit seen;
        seen = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        check_eq("done_seen", ROWW'(seen), ROWW'(1));
        @(negedge clk);
        check_eq("done_one_cycle", ROWW'(done), ROWW'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int dc;
        int wr0;
        int rdy_cyc;
        all_we    = '1;
        rst_ni    = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        row_cnt   = '0;
        addrtype.dtype = DtFp32;
        res_valid = '0;
        res_data  = '0;
        wr_ready  = 1'b0;

        @(negedge clk);
        check_eq("rst_busy", ROWW'(busy), ROWW'(0));
        check_eq("rst_we", ROWW'(we), ROWW'(0));
        check_eq("rst_done", ROWW'(done), ROWW'(0));
        check_eq("rst_overflow", ROWW'(overflow), ROWW'(0));
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Basic three-row job with an always-ready SRAM.
        fill_rows();
        wr_ready = 1'b1;
        wr0 = nwr;
        start_job(32'h100, 8'd3, DtFp32);
        check_eq("basic_busy", ROWW'(busy), ROWW'(1));
        expect_rows(32'h100, 0, 3, 1'b0);
        send_rows(0, 3, 1'b0);
        wait_done(dc);
        check_eq("basic_done_timing", ROWW'(dc), ROWW'(last_wr_cyc + 1));
        check_eq("basic_nwr", ROWW'(nwr - wr0), ROWW'(3));
        check_eq("basic_idle", ROWW'(busy), ROWW'(0));

        // Back-pressure: four rows held while the SRAM stalls.
        fill_rows();
        wr_ready = 1'b0;
        wr0 = nwr;
        start_job(32'h200, 8'd4, DtInt8);
        expect_rows(32'h200, 0, 4, 1'b0);
        send_rows(0, 4, 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("bp_we", ROWW'(we), ROWW'(all_we));
            check_eq("bp_addr_hold", ROWW'(wraddr), ROWW'(sb[0].addr));
            check_eq("bp_data_hold", wrdata, sb[0].data);
            check_eq("bp_no_overflow", ROWW'(overflow), ROWW'(0));
        end
        @(posedge clk); #1;
        wr_ready = 1'b1;
        rdy_cyc = cyc;
        wait_done(dc);
        check_eq("bp_nwr", ROWW'(nwr - wr0), ROWW'(4));
        check_eq("bp_consecutive", ROWW'(last_wr_cyc), ROWW'(rdy_cyc + 3));

        // Overflow: six rows into a four-deep FIFO with no drain.
        fill_rows();
        wr_ready = 1'b0;
        wr0 = nwr;
        start_job(32'h300, 8'd6, DtInt4);
        expect_rows(32'h300, 0, DEPTH, 1'b0);
        send_rows(0, 6, 1'b0);
        @(negedge clk);
        check_eq("ovf_flag", ROWW'(overflow), ROWW'(1));
        @(posedge clk); #1;
        wr_ready = 1'b1;
        idle(8);
        check_eq("ovf_nwr", ROWW'(nwr - wr0), ROWW'(DEPTH));
        check_eq("ovf_sb_drained", ROWW'(sb.size()), ROWW'(0));
        check_eq("ovf_still_busy", ROWW'(busy), ROWW'(1));
        expect_rows(32'h300, 4, 2, 1'b0);
        send_rows(4, 2, 1'b0);
        wait_done(dc);
        check_eq("ovf_total_nwr", ROWW'(nwr - wr0), ROWW'(6));
        check_eq("ovf_sticky", ROWW'(overflow), ROWW'(1));

        // FP16 strobes and upper-half masking.
        fill_rows();
        tab[0][0] = 32'hABCD1234;
        wr0 = nwr;
        start_job(32'h400, 8'd1, DtFp16);
        check_eq("fp16_ovf_cleared", ROWW'(overflow), ROWW'(0));
        expect_rows(32'h400, 0, 1, 1'b1);
        send_rows(0, 1, 1'b0);
        wait_done(dc);
        check_eq("fp16_nwr", ROWW'(nwr - wr0), ROWW'(1));
        check_eq("fp16_lane0", ROWW'(last_wrdata[31:0]), ROWW'(32'h0000_1234));
        check_eq("fp16_strb_lane0", ROWW'(last_wstrb[3:0]), ROWW'(4'b0011));

        // Zero-row job: done next cycle, never busy, no write.
        wr0 = nwr;
        start_job(32'h500, 8'd0, DtFp32);
        @(negedge clk);
        check_eq("zero_done", ROWW'(done), ROWW'(1));
        check_eq("zero_busy", ROWW'(busy), ROWW'(0));
        @(negedge clk);
        check_eq("zero_done_pulse", ROWW'(done), ROWW'(0));

        // Rows arriving while idle are ignored.
        fill_rows();
        send_rows(0, 2, 1'b0);
        idle(10);
        check_eq("idle_rows_nwr", ROWW'(nwr - wr0), ROWW'(0));

        // Start while collecting is ignored; reset mid-job drops pending writes.
        fill_rows();
        wr_ready = 1'b0;
        start_job(32'h600, 8'd2, DtFp32);
        send_rows(0, 2, 1'b0);
        start_job(32'h700, 8'd5, DtFp32);
        @(negedge clk);
        check_eq("restart_ignored", ROWW'(wraddr), ROWW'(32'h600));
        check_eq("pending_we", ROWW'(we), ROWW'(all_we));
        @(posedge clk); #3;
        rst_ni = 1'b0;
        #1;
        check_eq("rst_mid_we", ROWW'(we), ROWW'(0));
        check_eq("rst_mid_busy", ROWW'(busy), ROWW'(0));
        sb.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        wr_ready = 1'b1;
        wr0 = nwr;
        idle(10);
        check_eq("rst_no_writes", ROWW'(nwr - wr0), ROWW'(0));

`ifdef CONTROL_C_SKEW_CHECK_EN
        // Lane 3 arrives one cycle early: row is partial and must not be written.
        fill_rows();
        wr0 = nwr;
        start_job(32'h800, 8'd1, DtFp32);
        check_eq("skew_cleared", ROWW'(skew_err), ROWW'(0));
        send_rows(0, 1, 1'b1);
        idle(6);
        check_eq("skew_err", ROWW'(skew_err), ROWW'(1));
        check_eq("skew_no_write", ROWW'(nwr - wr0), ROWW'(0));
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
`endif

        idle(2);
        check_eq("sb_empty_end", ROWW'(sb.size()), ROWW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/control_c_writer.md
Name: control_c_writer

Overview:
- Write-back end of the systolic datapath: collects 8 skewed result lanes from the PE array and writes aligned rows into the C SRAM banks.
- Operand readers skew enable/address by one cycle per lane toward the PEs. This block removes that skew (lane i delayed LANES-1-i cycles) and buffers aligned rows in a small FIFO against SRAM back-pressure.
- Issues one shared row address per write and counts rows to completion.

Parameters:
- LANES, 8, number of PE result lanes / C SRAM banks
- DW, 32, result word width per lane
- AW, 32, SRAM address width
- FIFO_DEPTH, 4, aligned-row buffer depth (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle job start; honoured only in IDLE
- base_addr  in  AW  first row address, latched on start
- row_cnt  in  8  rows to write, latched on start
- addrtype  in  params::addrgen_t  datatype selects write strobes
- res_valid  in  LANES  per-lane result valid; lane i lags lane 0 by i cycles
- res_data  in  LANES x DW  per-lane result word
- wr_ready  in  1  SRAM accepts write this cycle
- we  out  LANES  per-bank write enable (all-ones or all-zero)
- wstrb  out  LANES x 4  per-bank byte strobes
- wraddr  out  AW  shared row address
- wrdata  out  LANES x DW  row data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the last row is written
- overflow  out  1  sticky; a row was dropped because the FIFO was full

Behaviour:
- Reset (rst low, async) clears all state: IDLE, FIFO empty, counters 0, we=0, done=0, busy=0, overflow=0. Reset mid-job abandons the job and leaves no write outstanding.
- De-skew: lane i's valid and data pass through LANES-1-i register stages; lane 7 has zero delay. A row is aligned in the cycle where all delayed valids are 1.
- FSM states: IDLE, COLLECT, DONE.
  - IDLE -> COLLECT on start with row_cnt != 0. Latch base_addr and row_cnt; clear pushed/written counters and overflow.
  - start with row_cnt == 0 pulses done in the next cycle and stays in IDLE.
  - COLLECT -> DONE in the cycle after the written count reaches row_cnt.
  - DONE asserts done=1 for one cycle -> IDLE.
  - start outside IDLE is ignored.
- Push rule: an aligned row in COLLECT with pushed < row_cnt is pushed into the FIFO and pushed increments. Aligned rows in IDLE/DONE, or beyond row_cnt, are discarded silently.
- Full: a push while full with no pop that cycle drops the row, sets overflow, and does not increment pushed. Push and pop in the same cycle while full is legal and loses nothing.
- Write handshake:
  - we = all-ones when the FIFO is non-empty and state is COLLECT.
  - A transfer occurs when we and wr_ready are both 1; it pops the FIFO and increments written.
  - wraddr = latched base + written (AW-bit wrap on overflow).
  - Outputs stay stable while wr_ready=0.
- Latency: lane 7 valid at cycle T gives we=1 at T+1 (empty FIFO). Steady-state throughput is one row per cycle.
- Strobes: FP16 gives wstrb=4'b0011 and wrdata[31:16]=0 per lane. INT8/INT4/other gives wstrb=4'b1111 and data passed through.

Optional Feature:
- Macro CONTROL_C_SKEW_CHECK_EN.
- When defined: if any delayed lane valid is 1 but not all are 1 in the same cycle, the row is not pushed and an extra sticky output skew_err (1 bit, reset 0, cleared on start) is set.
- When undefined: the port is absent, and a partial row is discarded with no flag.

Decomposition:
- params package: reuse addrgen_t and the datatype enum; add the state enum ctlc_state_t and the FP16 strobe constant.
- One sub-module, control_c_fifo: a synchronous LANES x DW row FIFO with push/pop/full/empty and a registered head.

Test Plan:
- Basic: base_addr=0x100, row_cnt=3, FP32-class datatype, ideal skew, wr_ready=1 -> three writes to addresses 0x100/0x101/0x102 with lane data intact; done pulses one cycle after the third write.
- Back-pressure: row_cnt=4, wr_ready=0 for 6 cycles -> 4 rows held, no overflow, and wraddr/wrdata stable. Then wr_ready=1 -> four consecutive writes.
- Overflow: FIFO_DEPTH=4, row_cnt=6, wr_ready=0 throughout arrival -> overflow=1 and exactly 4 rows are written once ready.
- FP16: res_data lane0=0xABCD1234 -> wstrb=4'b0011 and wrdata lane0=0x00001234.
- Boundaries: start with row_cnt=0 -> done next cycle, no we. Rows arriving in IDLE -> no we. rst low during COLLECT -> we=0 immediately, busy=0.
- Skew check (macro on): lane 3 valid one cycle early -> skew_err=1 and that row is not written.
